// File: rtl/t03_pc_sequencer.sv
// Program counter owner and fetch/execute sequencer for the team_03 core.
// Optional stats outputs are enabled by defining T03_PC_SEQ_STATS_EN.
module t03_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_W     = 8
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic        halt,
    input  logic        fetch_ack,
    input  logic        ex_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_req,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        flush,
    output logic        bus_err,
    output logic        misalign_err,
    output logic        halted
`ifdef T03_PC_SEQ_STATS_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StWaitEx, StHalt} state_t;

    // Value of the wait counter on the last no-ack cycle before a bus error.
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              misalign_q, misalign_d;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            to_cnt_q   <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            to_cnt_q   <= to_cnt_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        to_cnt_d    = to_cnt_q;
        bus_err_d   = bus_err_q;
        misalign_d  = misalign_q;
        fetch_req   = 1'b0;
        instr_valid = 1'b0;
        flush       = 1'b0;
        case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StHalt;
                end else if (en) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    instr_valid = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = StWaitEx;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == ToLast) begin
                        bus_err_d = 1'b1;
                        state_d   = StHalt;
                    end
                end
            end
            StWaitEx: begin
                if (ex_done) begin
                    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                        // Misaligned redirect: keep the old pc so the fault is visible.
                        misalign_d = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        if (branch_taken) begin
                            pc_d  = branch_target;
                            flush = 1'b1;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                        state_d = halt ? StHalt : StFetch;
                    end
                end
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc           = pc_q;
    assign bus_err      = bus_err_q;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == StHalt);

`ifdef T03_PC_SEQ_STATS_EN
    logic [31:0] taken_q, retired_q, stall_q;
    logic        ev_retire, ev_taken, ev_stall;

    assign ev_retire = (state_q == StWaitEx) && ex_done;
    assign ev_taken  = ev_retire && branch_taken;
    assign ev_stall  = (state_q == StFetch) && !fetch_ack;

    // Events only occur in FETCH/WAIT_EX, so the counters freeze in HALT.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            taken_q   <= '0;
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (ev_taken && (taken_q != '1)) taken_q <= taken_q + 32'd1;
            if (ev_retire && (retired_q != '1)) retired_q <= retired_q + 32'd1;
            if (ev_stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign taken_cnt   = taken_q;
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_t03_pc_sequencer.sv
// Bench for t03_pc_sequencer: directed plan steps plus random traffic against a
// cycle-level reference model; stats checks when T03_PC_SEQ_STATS_EN is defined.
module tb_t03_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 255;
    localparam int          TO_W     = 8;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_WAIT  = 2;
    localparam int P_HALT  = 3;

    logic        clk = 1'b0;
    logic        nRst, en, halt, fetch_ack, ex_done, branch_taken;
    logic [31:0] branch_target;
    logic        fetch_req, instr_valid, flush, bus_err, misalign_err, halted;
    logic [31:0] pc;
`ifdef T03_PC_SEQ_STATS_EN
    logic [31:0] taken_cnt, retired_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    t03_pc_sequencer #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .en           (en),
        .halt         (halt),
        .fetch_ack    (fetch_ack),
        .ex_done      (ex_done),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_req    (fetch_req),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .flush        (flush),
        .bus_err      (bus_err),
        .misalign_err (misalign_err),
        .halted       (halted)
`ifdef T03_PC_SEQ_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_iv  = 0;
    int n_fl  = 0;

    // Reference model: abstract phase, pc, no-ack wait count, sticky flags, stats.
    int          m_ph;
    logic [31:0] m_pc;
    int          m_waits;
    logic        m_berr, m_merr;
    logic [31:0] m_taken, m_ret, m_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_pc = RESET_PC; m_waits = 0;
        m_berr = 1'b0; m_merr = 1'b0;
        m_taken = '0; m_ret = '0; m_stall = '0;
    endtask

    task automatic model_update();
        if (!nRst) begin
            model_reset();
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (halt) m_ph = P_HALT;
                    else if (en) begin m_ph = P_FETCH; m_waits = 0; end
                end
                P_FETCH: begin
                    if (fetch_ack) begin
                        m_ph = P_WAIT;
                        m_waits = 0;
                    end else begin
                        m_waits++;
                        m_stall = sat_inc(m_stall);
                        if (m_waits == TIMEOUT) begin m_berr = 1'b1; m_ph = P_HALT; end
                    end
                end
                P_WAIT: begin
                    if (ex_done) begin
                        m_ret = sat_inc(m_ret);
                        if (branch_taken) m_taken = sat_inc(m_taken);
                        if (branch_taken && (branch_target % 4 != 0)) begin
                            m_merr = 1'b1;
                            m_ph = P_HALT;
                        end else begin
                            m_pc = branch_taken ? branch_target : m_pc + 32'd4;
                            m_ph = halt ? P_HALT : P_FETCH;
                            m_waits = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance it.
    task automatic step();
        logic e_fl;
        @(negedge clk);
        e_fl = (m_ph == P_WAIT) && ex_done && branch_taken && (branch_target % 4 == 0);
        chk("pc", pc, m_pc);
        chk("fetch_req", fetch_req, (m_ph == P_FETCH));
        chk("instr_valid", instr_valid, (m_ph == P_FETCH) && fetch_ack);
        chk("flush", flush, e_fl);
        chk("bus_err", bus_err, m_berr);
        chk("misalign_err", misalign_err, m_merr);
        chk("halted", halted, (m_ph == P_HALT));
`ifdef T03_PC_SEQ_STATS_EN
        chk("taken_cnt", taken_cnt, m_taken);
        chk("retired_cnt", retired_cnt, m_ret);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (instr_valid === 1'b1) n_iv++;
        if (flush === 1'b1) n_fl++;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic n, input logic e, input logic h, input logic a,
                         input logic x, input logic t, input logic [31:0] tg);
        nRst = n; en = e; halt = h; fetch_ack = a;
        ex_done = x; branch_taken = t; branch_target = tg;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
    endtask

    task automatic start();
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        step();
    endtask

    // One instruction: `stalls` no-ack cycles, an ack, then ex_done.
    task automatic retire(input int stalls, input logic t, input logic [31:0] tg,
                          input logic h);
        for (int i = 0; i < stalls; i++) begin
            drive(1, 0, 0, 0, 0, 0, 32'h0);
            step();
        end
        drive(1, 0, 0, 1, 0, 0, 32'h0);
        step();
        drive(1, 0, h, 0, 1, t, tg);
        step();
    endtask

    initial begin
        logic [31:0] r;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        model_reset();

        // Sequential fetch 0,4,8 -> 12.
        do_reset();
        start();
        n_iv = 0; n_fl = 0;
        for (int i = 0; i < 3; i++) retire(0, 1'b0, 32'h0, 1'b0);
        chk("seq_pc", pc, 32'd12);
        chk("seq_iv_count", n_iv, 3);
        chk("seq_flush_count", n_fl, 0);

        // Aligned redirect from pc=8.
        do_reset();
        start();
        retire(0, 1'b0, 32'h0, 1'b0);
        retire(0, 1'b0, 32'h0, 1'b0);
        n_fl = 0;
        retire(0, 1'b1, 32'h0000_0040, 1'b0);
        chk("redir_flush_count", n_fl, 1);
        chk("redir_pc", pc, 32'h40);
        chk("redir_fetch_req", fetch_req, 1'b1);

        // PC wrap at the top of the address space.
        retire(0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        retire(0, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // Misaligned redirect from pc=8.
        do_reset();
        start();
        retire(0, 1'b0, 32'h0, 1'b0);
        retire(0, 1'b0, 32'h0, 1'b0);
        retire(0, 1'b1, 32'h0000_0042, 1'b0);
        chk("mis_pc", pc, 32'd8);
        chk("mis_err", misalign_err, 1'b1);
        chk("mis_halted", halted, 1'b1);
        chk("mis_fetch_req", fetch_req, 1'b0);

        // Fetch timeout.
        do_reset();
        start();
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(1, 0, 0, 0, 0, 0, 32'h0);
            step();
        end
        chk("to_bus_err", bus_err, 1'b1);
        chk("to_halted", halted, 1'b1);

        // Ack on the last cycle before the limit.
        do_reset();
        start();
        n_iv = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            drive(1, 0, 0, 0, 0, 0, 32'h0);
            step();
        end
        drive(1, 0, 0, 1, 0, 0, 32'h0);
        step();
        chk("late_ack_iv", n_iv, 1);
        chk("late_ack_bus_err", bus_err, 1'b0);
        chk("late_ack_halted", halted, 1'b0);

        // halt together with ex_done at pc=0x10, then reset.
        do_reset();
        start();
        for (int i = 0; i < 4; i++) retire(0, 1'b0, 32'h0, 1'b0);
        retire(0, 1'b0, 32'h0, 1'b1);
        chk("halt_pc", pc, 32'h14);
        chk("halt_halted", halted, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1, 1, 0, 32'h0);
            step();
        end
        do_reset();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_halted", halted, 1'b0);
        chk("rst_fetch_req", fetch_req, 1'b0);

`ifdef T03_PC_SEQ_STATS_EN
        do_reset();
        start();
        retire(2, 1'b1, 32'h0000_0100, 1'b0);
        retire(1, 1'b0, 32'h0, 1'b0);
        retire(1, 1'b1, 32'h0000_0200, 1'b0);
        retire(0, 1'b0, 32'h0, 1'b0);
        retire(0, 1'b0, 32'h0, 1'b0);
        chk("stats_taken", taken_cnt, 32'd2);
        chk("stats_retired", retired_cnt, 32'd5);
        chk("stats_stall", stall_cnt, 32'd4);
`endif

        // Random traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = $urandom();
            r = r & ~32'h3;
            if ($urandom_range(15) == 0) r = r | 32'($urandom_range(3, 1));
            drive(($urandom_range(39) != 0), 1'($urandom_range(1)),
                  ($urandom_range(29) == 0), ($urandom_range(2) == 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)), r);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
